memory_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage. It consumes the EX/MEM register (result, store data, 12-bit control), drives a request/grant/response data-memory port, aligns and extends load data, and registers the MEM/WB values. While a memory access is outstanding it stalls the front of the pipeline and inserts bubbles into writeback.

---
 rtl/memory_stage_if.sv | 24 ++
 rtl/memory_stage.sv | 194 +++++++++++++++++++
 tb/tb_memory_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
// Request, grant and response signals.
interface memory_stage_if #(
    parameter int size = 32
);
    logic            req;
    logic            we;
    logic [size-1:0] addr;
    logic [3:0]      be;
    logic [size-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [size-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory requests, aligns load data and registers MEM/WB.
// Stalls upstream while an access is outstanding and sends bubbles to writeback.
module memory_stage #(
    parameter int size = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [size-1:0]   result_i,
    input  logic [size-1:0]   store_data_i,
    input  logic [11:0]       control_i,
    output logic [size-1:0]   fwd_data_o,
    output logic              stall_o,
    memory_stage_if.master    dmem,
    output logic              misaligned_o,
    output logic [size-1:0]   wb_data_o,
    output logic [4:0]        wb_rd_o,
    output logic              wb_we_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e state_q, state_d;

    logic [size-1:0] wbData_q, wbData_d;
    logic [4:0]      wbRd_q, wbRd_d;
    logic            wbWe_q, wbWe_d;
    logic            misaligned_q, misaligned_d;

    logic [4:0]      rd;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic [1:0]      accessSize;
    logic            loadUnsigned;
    logic            unusedPcLink;

    logic            isHalf;
    logic            isWord;
    logic            misalignedAccess;
    logic            memOp;
    logic            isLoad;
    logic            complete;
    logic            req;

    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [size-1:0] loadData;

    assign rd           = control_i[11:7];
    assign regWrite     = control_i[6];
    assign unusedPcLink = control_i[5];
    assign memRead      = control_i[4];
    assign memWrite     = control_i[3];
    assign accessSize   = control_i[2:1];
    assign loadUnsigned = control_i[0];

    // Size 2'b11 behaves as a word access.
    assign isHalf = (accessSize == 2'b01);
    assign isWord = accessSize[1];

    assign misalignedAccess = (memRead | memWrite)
                            & ((isHalf & result_i[0]) | (isWord & (result_i[1:0] != 2'b00)));
    assign memOp  = (memRead | memWrite) & ~misalignedAccess;
    assign isLoad = memRead & ~memWrite;

    assign fwd_data_o = result_i;

    // Handshake FSM: decides request, stall and whether the EX/MEM op completes this cycle.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall_o  = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (memOp) begin
                    req = 1'b1;
                    if (dmem.gnt && memWrite) begin
                        complete = 1'b1;
                    end else if (dmem.gnt) begin
                        state_d = WAIT_RVALID;
                        stall_o = 1'b1;
                    end else begin
                        state_d = WAIT_GNT;
                        stall_o = 1'b1;
                    end
                end else begin
                    complete = 1'b1;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (dmem.gnt && memWrite) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else if (dmem.gnt) begin
                    state_d = WAIT_RVALID;
                    stall_o = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (dmem.rvalid) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem.req  = req;
    assign dmem.we   = memWrite;
    assign dmem.addr = {result_i[size-1:2], 2'b00};

    always_comb begin
        dmem.be    = 4'b0000;
        dmem.wdata = store_data_i;
        if (isWord) begin
            dmem.be = 4'b1111;
        end else if (isHalf) begin
            dmem.be    = 4'b0011 << {result_i[1], 1'b0};
            dmem.wdata = {2{store_data_i[15:0]}};
        end else begin
            dmem.be    = 4'b0001 << result_i[1:0];
            dmem.wdata = {4{store_data_i[7:0]}};
        end
        if (!req) begin
            dmem.be = 4'b0000;
        end
    end

    // Pick the addressed lane out of the read word and extend it to full width.
    always_comb begin
        case (result_i[1:0])
            2'b00:   loadByte = dmem.rdata[7:0];
            2'b01:   loadByte = dmem.rdata[15:8];
            2'b10:   loadByte = dmem.rdata[23:16];
            default: loadByte = dmem.rdata[31:24];
        endcase
        loadHalf = result_i[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        if (isWord) begin
            loadData = dmem.rdata;
        end else if (isHalf) begin
            loadData = {{16{~loadUnsigned & loadHalf[15]}}, loadHalf};
        end else begin
            loadData = {{24{~loadUnsigned & loadByte[7]}}, loadByte};
        end
    end

    // Stall cycles become bubbles that keep the last data and rd.
    always_comb begin
        wbData_d     = wbData_q;
        wbRd_d       = wbRd_q;
        wbWe_d       = 1'b0;
        misaligned_d = (state_q == IDLE) & misalignedAccess;
        if (complete) begin
            wbData_d = (isLoad && memOp) ? loadData : result_i;
            wbRd_d   = rd;
            wbWe_d   = regWrite & ~memWrite & ~misalignedAccess;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wbData_q     <= '0;
            wbRd_q       <= '0;
            wbWe_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbData_q     <= wbData_d;
            wbRd_q       <= wbRd_d;
            wbWe_q       <= wbWe_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign wb_data_o    = wbData_q;
    assign wb_rd_o      = wbRd_q;
    assign wb_we_o      = wbWe_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases followed by random ops,
// all checked against an arithmetic model of the stage's rules.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] result_i;
    logic [31:0] store_data_i;
    logic [11:0] control_i;
    logic [31:0] fwd_data_o;
    logic        stall_o;
    logic        misaligned_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;

    memory_stage_if #(.size(32)) dmem ();

    memory_stage #(.size(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .result_i     (result_i),
        .store_data_i (store_data_i),
        .control_i    (control_i),
        .fwd_data_o   (fwd_data_o),
        .stall_o      (stall_o),
        .dmem         (dmem.master),
        .misaligned_o (misaligned_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .wb_we_o      (wb_we_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expWbData;
    logic [4:0]  expWbRd;
    bit          dataKnown;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit isMisaligned(input int unsigned addr, input int unsigned sz);
        return (sz == 1 && addr % 2 != 0) || (sz >= 2 && addr % 4 != 0);
    endfunction

    function automatic logic [3:0] modelBe(input int unsigned addr, input int unsigned sz);
        if (sz == 0) return 4'(1 << (addr % 4));
        if (sz == 1) return 4'(3 << (addr & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input int unsigned sd, input int unsigned sz);
        if (sz == 0) return (sd & 255) * 32'h0101_0101;
        if (sz == 1) return (sd & 65535) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] modelLoad(input int unsigned rdata, input int unsigned addr,
                                              input int unsigned sz, input bit uns);
        int unsigned v;
        if (sz >= 2) return rdata;
        if (sz == 0) begin
            v = (rdata >> (8 * (addr % 4))) & 255;
            if (!uns && v >= 128) v = v - 256;
        end else begin
            v = (rdata >> (8 * (addr & 2))) & 65535;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // Presents one op starting just after a rising edge; n = grant wait, m = grant-to-rvalid.
    task automatic applyStimulus(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                                 input bit regWr, input bit memRd, input bit memWr,
                                 input int unsigned sz, input bit uns,
                                 input int unsigned n, input int unsigned m, input logic [31:0] rdata);
        int  total;
        bit  mis;
        bit  memOp;
        bit  load;
        mis   = (memRd | memWr) && isMisaligned(res, sz);
        memOp = (memRd | memWr) && !mis;
        load  = memRd && !memWr;
        if (!memOp)     total = 1;
        else if (memWr) total = n + 1;
        else            total = n + m + 1;

        result_i     = res;
        store_data_i = sd;
        control_i    = {rd, regWr, 1'($urandom_range(0, 1)), memRd, memWr, 2'(sz), uns};

        for (int k = 0; k < total; k++) begin
            dmem.gnt = memOp && (k == n);
            if (memOp && load && k == n + m) begin
                dmem.rvalid = 1'b1;
                dmem.rdata  = rdata;
            end else begin
                dmem.rvalid = (!memOp || k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem.rdata  = $urandom;
            end
            #3;
            checkOutput("stall", 32'(stall_o), 32'(k < total - 1));
            checkOutput("fwd", fwd_data_o, res);
            checkOutput("req", 32'(dmem.req), 32'(memOp && k <= n));
            if (memOp && k <= n) begin
                checkOutput("we", 32'(dmem.we), 32'(memWr));
                checkOutput("addr", dmem.addr, res & 32'hFFFF_FFFC);
                checkOutput("be", 32'(dmem.be), 32'(modelBe(res, sz)));
                if (memWr) checkOutput("wdata", dmem.wdata, modelWdata(sd, sz));
            end else begin
                checkOutput("be_idle", 32'(dmem.be), 32'd0);
            end
            @(posedge clk);
            #1;
            if (k == total - 1) begin
                expWbRd = rd;
                if (!mis) begin
                    expWbData = (memOp && load) ? modelLoad(rdata, res, sz, uns) : res;
                    dataKnown = 1'b1;
                end else begin
                    dataKnown = 1'b0;
                end
                checkOutput("wb_we", 32'(wb_we_o), 32'(regWr && !memWr && !mis));
                checkOutput("misaligned", 32'(misaligned_o), 32'(mis));
            end else begin
                checkOutput("bubble_we", 32'(wb_we_o), 32'd0);
                checkOutput("misaligned", 32'(misaligned_o), 32'd0);
            end
            checkOutput("wb_rd", 32'(wb_rd_o), 32'(expWbRd));
            if (dataKnown) checkOutput("wb_data", wb_data_o, expWbData);
        end
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
    endtask

    initial begin
        int unsigned sz;
        int unsigned kind;
        logic [31:0] addr;
        reset        = 1'b0;
        result_i     = '0;
        store_data_i = '0;
        control_i    = '0;
        dmem.gnt     = 1'b0;
        dmem.rvalid  = 1'b0;
        dmem.rdata   = '0;
        expWbData    = '0;
        expWbRd      = '0;
        dataKnown    = 1'b1;

        #12;
        checkOutput("rst_wb_data", wb_data_o, 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        checkOutput("rst_wb_we", 32'(wb_we_o), 32'd0);
        checkOutput("rst_misaligned", 32'(misaligned_o), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 2, 0, 0, 1, 32'h0);
        checkOutput("nonmem_data", wb_data_o, 32'h0000_1234);
        checkOutput("nonmem_rd", 32'(wb_rd_o), 32'd5);
        checkOutput("nonmem_we", 32'(wb_we_o), 32'd1);

        applyStimulus(32'h0000_0103, 32'h0, 5'd7, 1, 1, 0, 0, 0, 0, 2, 32'h80FF_FF7F);
        checkOutput("lb_data", wb_data_o, 32'hFFFF_FF80);

        applyStimulus(32'h0000_0202, 32'h0, 5'd9, 1, 1, 0, 1, 1, 1, 1, 32'hBEEF_0000);
        checkOutput("lhu_data", wb_data_o, 32'h0000_BEEF);

        applyStimulus(32'h0000_0001, 32'h0000_00AB, 5'd3, 1, 0, 1, 0, 0, 3, 1, 32'h0);
        checkOutput("sb_we", 32'(wb_we_o), 32'd0);

        applyStimulus(32'h0000_0006, 32'h0, 5'd4, 1, 1, 0, 2, 0, 0, 1, 32'h0);
        applyStimulus(32'h0000_0077, 32'h0, 5'd8, 1, 0, 0, 0, 0, 0, 1, 32'h0);

        // Reset while a load waits for its response.
        result_i  = 32'h0000_0040;
        control_i = {5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        dmem.gnt  = 1'b1;
        @(posedge clk);
        #1;
        dmem.gnt = 1'b0;
        #1;
        checkOutput("wait_rvalid_req", 32'(dmem.req), 32'd0);
        checkOutput("wait_rvalid_stall", 32'(stall_o), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_wb_data", wb_data_o, 32'd0);
        checkOutput("midrst_wb_rd", 32'(wb_rd_o), 32'd0);
        checkOutput("midrst_wb_we", 32'(wb_we_o), 32'd0);
        checkOutput("midrst_idle_req", 32'(dmem.req), 32'd1);
        result_i    = 32'h0000_55AA;
        control_i   = {5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checkOutput("inrst_wb_we", 32'(wb_we_o), 32'd0);
        checkOutput("inrst_misaligned", 32'(misaligned_o), 32'd0);
        reset = 1'b1;
        #2;
        checkOutput("postrst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("postrst_wb_data", wb_data_o, 32'h0000_55AA);
        checkOutput("postrst_wb_rd", 32'(wb_rd_o), 32'd10);
        checkOutput("postrst_wb_we", 32'(wb_we_o), 32'd1);
        dmem.rvalid = 1'b0;
        expWbData   = 32'h0000_55AA;
        expWbRd     = 5'd10;
        dataKnown   = 1'b1;

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            sz   = $urandom_range(0, 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) addr[0] = 1'b0;
                else if (sz >= 2) addr[1:0] = 2'b00;
            end
            applyStimulus(addr, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                          kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
